// File: rtl/parallel_serial_buf_pkg.sv
// Shared types and width helpers for the parallel-to-serial buffer.
package parallel_serial_pkg;

    // Default geometry of the serialiser; the queued entry type follows these widths.
    localparam int PS_WIDTH = 14;
    localparam int PS_LEN_W = 4;
    localparam int PS_DEPTH = 4;

    // Serialiser states.
    typedef enum logic {
        IDLE,
        SHIFT
    } ps_state_e;

    // One queued word: payload, effective bit count and bit order.
    typedef struct packed {
        logic [PS_WIDTH-1:0] data;
        logic [PS_LEN_W-1:0] len;
        logic                msb_first;
    } ps_entry_t;

    // Read/write pointer width for a power-of-two FIFO.
    function automatic int ps_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy counter width; it must hold 0..depth inclusive.
    function automatic int ps_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/parallel_serial_buf_fifo.sv
// Word FIFO with first-word-fall-through head; writes to a full FIFO are dropped.
module ps_word_fifo
    import parallel_serial_pkg::*;
#(
    parameter int DEPTH = PS_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  ps_entry_t wdata_i,
    output ps_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = ps_ptr_w(DEPTH);
    localparam int CNT_W = ps_cnt_w(DEPTH);

    ps_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are only meaningful under the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/parallel_serial_buf.sv
// Queued parallel-to-serial converter with per-word length and bit order.
module parallel_serial_buf
    import parallel_serial_pkg::*;
#(
    parameter int PARALLEL_PORT_WIDTH = PS_WIDTH,
    parameter int BIT_LENGTH          = PS_LEN_W,
    parameter int DEPTH               = PS_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           dv_in,
    input  logic [PARALLEL_PORT_WIDTH-1:0] din,
    input  logic [BIT_LENGTH-1:0]          bit_lngt,
    input  logic                           msb_first,
    output logic                           ready_out,
    output logic                           overflow,
    output logic                           dout,
    output logic                           dout_valid,
    output logic                           dout_last
);

    localparam int W = PARALLEL_PORT_WIDTH;

    // Zero or out-of-range lengths mean a full-width word.
    function automatic logic [BIT_LENGTH-1:0] clamp_len(input logic [BIT_LENGTH-1:0] l);
        if (l == '0 || int'(l) > W) return BIT_LENGTH'(W);
        return l;
    endfunction

    ps_state_e             state_q, state_d;
    logic [W-1:0]          sr_q, sr_d;
    logic [BIT_LENGTH-1:0] cnt_q, cnt_d;
    logic                  msb_q, msb_d;
    logic                  dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  overflow_q;
    logic                  fifo_full, fifo_empty, fifo_pop;
    ps_entry_t             wr_entry, head;
    logic [W-1:0]          aligned;

    assign wr_entry = '{data: din, len: clamp_len(bit_lngt), msb_first: msb_first};

    ps_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (dv_in && !rst),
        .pop_i   (fifo_pop),
        .wdata_i (wr_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ready_out  = !fifo_full;
    assign overflow   = overflow_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;

    // Next bit selection: load a new word when idle or on the last bit, otherwise shift.
    // sr holds the bits still to send after the one being driven; cnt counts them.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        msb_d    = msb_q;
        dout_d   = 1'b0;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        aligned  = '0;
        if (state_q == IDLE || cnt_q == '0) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                state_d  = SHIFT;
                // MSB-first words are left-aligned so the first bit always sits at the top.
                aligned  = head.msb_first ? (head.data << (W - int'(head.len))) : head.data;
                dout_d   = head.msb_first ? aligned[W-1] : aligned[0];
                sr_d     = head.msb_first ? (aligned << 1) : (aligned >> 1);
                cnt_d    = head.len - 1'b1;
                msb_d    = head.msb_first;
                valid_d  = 1'b1;
                last_d   = (head.len == BIT_LENGTH'(1));
            end else begin
                state_d = IDLE;
            end
        end else begin
            dout_d  = msb_q ? sr_q[W-1] : sr_q[0];
            sr_d    = msb_q ? (sr_q << 1) : (sr_q >> 1);
            cnt_d   = cnt_q - 1'b1;
            valid_d = 1'b1;
            last_d  = (cnt_q == BIT_LENGTH'(1));
        end
    end

    // Control and output registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dout_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            overflow_q <= dv_in && !ready_out;
        end
    end

    // Shift data path; only read while a word is active, so it needs no reset.
    always_ff @(posedge clk) begin
        sr_q  <= sr_d;
        msb_q <= msb_d;
    end

endmodule

// File: tb/tb_parallel_serial_buf.sv
// Directed plus randomized bench for parallel_serial_buf against a queue-based model.
module tb_parallel_serial_buf;

    localparam int W  = 14;
    localparam int LW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          dv_in;
    logic [W-1:0]  din;
    logic [LW-1:0] bit_lngt;
    logic          msb_first;
    logic          ready_out, overflow, dout, dout_valid, dout_last;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] d;
        int           len;
        logic         msb;
    } word_t;

    word_t mq[$];
    logic  cb[$];
    logic  e_dout, e_valid, e_last, e_ovf, e_ready;

    parallel_serial_buf #(
        .PARALLEL_PORT_WIDTH(W),
        .BIT_LENGTH(LW),
        .DEPTH(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dv_in      (dv_in),
        .din        (din),
        .bit_lngt   (bit_lngt),
        .msb_first  (msb_first),
        .ready_out  (ready_out),
        .overflow   (overflow),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Model of one clock edge: a pending-word queue and the bit stream of the active word.
    task automatic model_step(input logic r, input logic dv, input logic [W-1:0] d,
                              input logic [LW-1:0] bl, input logic m);
        bit    rdy_pre;
        word_t w;
        int    len;
        if (r) begin
            mq.delete();
            cb.delete();
            e_dout  = 1'b0;
            e_valid = 1'b0;
            e_last  = 1'b0;
            e_ovf   = 1'b0;
        end else begin
            rdy_pre = (mq.size() < D);
            e_ovf   = dv && !rdy_pre;
            if (cb.size() == 0 && mq.size() > 0) begin
                w = mq.pop_front();
                for (int i = 0; i < w.len; i++)
                    cb.push_back(w.msb ? w.d[w.len-1-i] : w.d[i]);
            end
            if (cb.size() > 0) begin
                e_dout  = cb.pop_front();
                e_valid = 1'b1;
                e_last  = (cb.size() == 0);
            end else begin
                e_dout  = 1'b0;
                e_valid = 1'b0;
                e_last  = 1'b0;
            end
            if (dv && rdy_pre) begin
                len = (bl == 0 || int'(bl) > W) ? W : int'(bl);
                w.d = d; w.len = len; w.msb = m;
                mq.push_back(w);
            end
        end
        e_ready = (mq.size() < D);
    endtask

    task automatic cyc(input logic r, input logic dv, input logic [W-1:0] d,
                       input logic [LW-1:0] bl, input logic m);
        rst = r; dv_in = dv; din = d; bit_lngt = bl; msb_first = m;
        @(posedge clk);
        model_step(r, dv, d, bl, m);
        #1;
        chk("dout", dout, e_dout);
        chk("dout_valid", dout_valid, e_valid);
        chk("dout_last", dout_last, e_last);
        chk("overflow", overflow, e_ovf);
        chk("ready_out", ready_out, e_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        // Reset
        cyc(1'b1, 1'b0, '0, '0, 1'b0);
        cyc(1'b1, 1'b1, 14'h3fff, 4'd5, 1'b1);
        idle(2);

        // Single 14-bit word, MSB first
        cyc(1'b0, 1'b1, 14'd9, 4'd14, 1'b1);
        idle(16);

        // 4-bit word, LSB first, with junk above the length
        cyc(1'b0, 1'b1, 14'h3ffc, 4'd4, 1'b0);
        idle(6);

        // Four back-to-back 3-bit words
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, W'($urandom), 4'd3, 1'(i & 1));
        idle(15);

        // Overfill the FIFO
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, W'($urandom), 4'd14, 1'($urandom));
        idle(80);

        // Out-of-range lengths
        cyc(1'b0, 1'b1, W'($urandom), 4'd0, 1'b1);
        cyc(1'b0, 1'b1, W'($urandom), 4'd15, 1'b0);
        idle(32);

        // Reset mid-word with words queued
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, W'($urandom), 4'd8, 1'($urandom));
        idle(2);
        cyc(1'b1, 1'b1, W'($urandom), 4'd8, 1'b1);
        idle(20);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                W'($urandom), LW'($urandom), 1'($urandom));
        idle(90);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
